// File: rtl/text_line_sequencer_if.sv
// Host-side buffer/control signals and renderer start/done handshake for the
// text line sequencer, grouped so the sequencer and its peers share one bundle.
interface text_line_sequencer_if #(
  parameter int unsigned DEPTH = 16
);
  logic                     wr_en;
  logic [6:0]               wr_char;
  logic                     buf_full;
  logic [$clog2(DEPTH):0]   buf_count;
  logic                     go;
  logic [10:0]              x_base;
  logic [10:0]              y_base;
  logic                     busy;
  logic                     finished;
  logic [6:0]               char_code;
  logic [10:0]              char_x0;
  logic [10:0]              char_y0;
  logic                     char_start;
  logic                     char_done;

  modport master (
    input  wr_en, wr_char, go, x_base, y_base, char_done,
    output buf_full, buf_count, busy, finished,
           char_code, char_x0, char_y0, char_start
  );

  modport slave (
    output wr_en, wr_char, go, x_base, y_base, char_done,
    input  buf_full, buf_count, busy, finished,
           char_code, char_x0, char_y0, char_start
  );
endinterface

// File: rtl/text_line_sequencer.sv
// Buffers host character codes and feeds them one at a time, with computed pen
// positions, to the 14-segment glyph renderer; handles newline and right-edge wrap.
module text_line_sequencer #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned CHAR_PITCH = 25,
  parameter int unsigned LINE_PITCH = 50,
  parameter int unsigned X_MAX      = 639,
  parameter logic [6:0]  NEWLINE    = 7'h0A
) (
  input logic                   clk,
  input logic                   reset,
  text_line_sequencer_if.master bus
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] FETCH   = 3'd1;
  localparam logic [2:0] START   = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] NEXT    = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;

  logic [2:0]    state;
  logic [6:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [10:0]   cur_x;
  logic [10:0]   cur_y;
  logic [10:0]   base_x;
  logic [6:0]    head;
  logic [11:0]   x_end;
  logic          full;
  logic          push;
  logic          pop;
  logic          wraps;

  assign full  = (count == DEPTH_C);
  assign push  = bus.wr_en && !full && (state == IDLE);
  assign head  = mem[rd_ptr];
  // 12-bit so a cursor near 2047 cannot alias back under X_MAX
  assign x_end = {1'b0, cur_x} + 12'(CHAR_PITCH - 1);
  assign wraps = (x_end > 12'(X_MAX)) && (cur_x != base_x);
  // A wrapping glyph stays at the head and is retried on the new line
  assign pop   = (state == FETCH) && ((head == NEWLINE) || !wraps);

  assign bus.buf_full   = full;
  assign bus.buf_count  = count;
  assign bus.busy       = (state != IDLE);
  assign bus.finished   = (state == DONE);
  assign bus.char_start = (state == START);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.wr_char;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      cur_x         <= '0;
      cur_y         <= '0;
      base_x        <= '0;
      bus.char_code <= '0;
      bus.char_x0   <= '0;
      bus.char_y0   <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        count  <= count + 1'b1;
      end else if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        count  <= count - 1'b1;
      end

      case (state)
        IDLE: begin
          if (bus.go) begin
            cur_x  <= bus.x_base;
            cur_y  <= bus.y_base;
            base_x <= bus.x_base;
            state  <= ((count != '0) || push) ? FETCH : DONE;
          end
        end
        FETCH: begin
          bus.char_code <= head;
          if (head == NEWLINE) begin
            cur_x <= base_x;
            cur_y <= cur_y + 11'(LINE_PITCH);
            state <= NEXT;
          end else if (wraps) begin
            cur_x <= base_x;
            cur_y <= cur_y + 11'(LINE_PITCH);
          end else begin
            bus.char_x0 <= cur_x;
            bus.char_y0 <= cur_y;
            state       <= START;
          end
        end
        START: begin
          if (bus.char_done) state <= RELEASE;
        end
        RELEASE: begin
          if (!bus.char_done) begin
            cur_x <= cur_x + 11'(CHAR_PITCH);
            state <= NEXT;
          end
        end
        NEXT:    state <= (count == '0) ? DONE : FETCH;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_text_line_sequencer.sv
// Directed bench for text_line_sequencer with a behavioural glyph renderer that
// logs every start and can hold done high after start falls.
module tb_text_line_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_line_sequencer_if #(.DEPTH(16)) bus();

  text_line_sequencer #(
    .DEPTH(16), .CHAR_PITCH(25), .LINE_PITCH(50), .X_MAX(639), .NEWLINE(7'h0A)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.master)
  );

  int passed = 0;
  int failed = 0;
  int total  = 0;

  logic [28:0] glyph_q[$];
  int   rend_lat  = 2;
  int   rend_hold = 0;
  int   viol      = 0;
  int   rcnt      = 0;
  int   rhold     = 0;
  logic prev_start = 1'b0;

  // Renderer model: done rises rend_lat cycles into start, falls rend_hold cycles after start drops
  always @(negedge clk) begin
    if (reset) begin
      bus.char_done = 1'b0;
      rcnt = 0;
      rhold = 0;
      prev_start = 1'b0;
    end else begin
      if (bus.char_start && !prev_start) begin
        if (bus.char_done) viol++;
        glyph_q.push_back({bus.char_code, bus.char_x0, bus.char_y0});
      end
      if (bus.char_start && !bus.char_done) begin
        rcnt++;
        if (rcnt >= rend_lat) begin
          bus.char_done = 1'b1;
          rcnt = 0;
          rhold = 0;
        end
      end else if (!bus.char_start && bus.char_done) begin
        if (rhold >= rend_hold) bus.char_done = 1'b0;
        else rhold++;
      end
      prev_start = bus.char_start;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] glyph(input logic [6:0] c, input logic [10:0] x,
                                        input logic [10:0] y);
    return {3'b000, c, x, y};
  endfunction

  function automatic logic [31:0] g(input int i);
    if (glyph_q.size() > i) return {3'b000, glyph_q[i]};
    return '1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_char(input logic [6:0] c);
    bus.wr_en   = 1'b1;
    bus.wr_char = c;
    tick();
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_run(input logic [10:0] x, input logic [10:0] y);
    bus.x_base = x;
    bus.y_base = y;
    bus.go     = 1'b1;
    tick();
    bus.go     = 1'b0;
  endtask

  task automatic wait_done(output int fins);
    fins = 0;
    for (int i = 0; i < 600; i++) begin
      tick();
      if (bus.finished) fins++;
      if (fins > 0 && !bus.busy) return;
    end
    chk("run_timeout_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int fins;
    logic found;
    reset = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_char = '0;
    bus.go = 1'b0;
    bus.x_base = '0;
    bus.y_base = '0;
    repeat (3) tick();
    chk("rst_busy",     32'(bus.busy),       32'd0);
    chk("rst_count",    32'(bus.buf_count),  32'd0);
    chk("rst_full",     32'(bus.buf_full),   32'd0);
    chk("rst_start",    32'(bus.char_start), 32'd0);
    chk("rst_finished", 32'(bus.finished),   32'd0);
    chk("rst_code",     32'(bus.char_code),  32'd0);
    reset = 1'b0;
    tick();

    // 'A','B' from (10,20): go-to-start latency and pitch advance
    push_char(7'h41);
    chk("ab_count1", 32'(bus.buf_count), 32'd1);
    push_char(7'h42);
    glyph_q.delete();
    start_run(11'd10, 11'd20);
    chk("ab_busy_fetch",  32'(bus.busy),       32'd1);
    chk("ab_start_fetch", 32'(bus.char_start), 32'd0);
    tick();
    chk("ab_start_lat", 32'(bus.char_start), 32'd1);
    chk("ab_code_lat",  32'(bus.char_code),  32'h41);
    wait_done(fins);
    chk("ab_fins",  32'(fins),           32'd1);
    chk("ab_count", 32'(bus.buf_count),  32'd0);
    chk("ab_busy",  32'(bus.busy),       32'd0);
    chk("ab_n",     32'(glyph_q.size()), 32'd2);
    chk("ab_g0",    g(0), glyph(7'h41, 11'd10, 11'd20));
    chk("ab_g1",    g(1), glyph(7'h42, 11'd35, 11'd20));

    // Overfill: codes 0x30..0x41, last two dropped
    for (int i = 0; i < 18; i++) begin
      push_char(7'(7'h30 + i));
      if (i == 15) begin
        chk("full_at16",  32'(bus.buf_full),  32'd1);
        chk("count_at16", 32'(bus.buf_count), 32'd16);
      end
    end
    chk("full_after18",  32'(bus.buf_full),  32'd1);
    chk("count_after18", 32'(bus.buf_count), 32'd16);
    glyph_q.delete();
    start_run(11'd0, 11'd0);
    wait_done(fins);
    chk("full_n",   32'(glyph_q.size()), 32'd16);
    chk("full_g0",  g(0),  glyph(7'h30, 11'd0, 11'd0));
    chk("full_g15", g(15), glyph(7'h3F, 11'd375, 11'd0));
    chk("full_empty", 32'(bus.buf_full), 32'd0);

    // Newline is not drawn and moves to the next line
    push_char(7'h48);
    push_char(7'h0A);
    push_char(7'h49);
    glyph_q.delete();
    start_run(11'd0, 11'd0);
    wait_done(fins);
    chk("nl_n",  32'(glyph_q.size()), 32'd2);
    chk("nl_g0", g(0), glyph(7'h48, 11'd0, 11'd0));
    chk("nl_g1", g(1), glyph(7'h49, 11'd0, 11'd50));

    // Right-edge wrap from x_base=600
    push_char(7'h58);
    push_char(7'h59);
    push_char(7'h5A);
    glyph_q.delete();
    start_run(11'd600, 11'd0);
    wait_done(fins);
    chk("wrap_n",  32'(glyph_q.size()), 32'd3);
    chk("wrap_g0", g(0), glyph(7'h58, 11'd600, 11'd0));
    chk("wrap_g1", g(1), glyph(7'h59, 11'd600, 11'd50));
    chk("wrap_g2", g(2), glyph(7'h5A, 11'd600, 11'd100));

    // Renderer holds done long after start falls
    rend_lat  = 1;
    rend_hold = 5;
    push_char(7'h50);
    push_char(7'h51);
    glyph_q.delete();
    start_run(11'd100, 11'd200);
    wait_done(fins);
    chk("hold_viol", 32'(viol),           32'd0);
    chk("hold_n",    32'(glyph_q.size()), 32'd2);
    chk("hold_g0",   g(0), glyph(7'h50, 11'd100, 11'd200));
    chk("hold_g1",   g(1), glyph(7'h51, 11'd125, 11'd200));
    chk("hold_fins", 32'(fins),           32'd1);

    // Write and go in the same idle cycle
    rend_lat  = 2;
    rend_hold = 0;
    glyph_q.delete();
    bus.wr_en   = 1'b1;
    bus.wr_char = 7'h4B;
    start_run(11'd5, 11'd7);
    bus.wr_en   = 1'b0;
    wait_done(fins);
    chk("wrgo_n",  32'(glyph_q.size()), 32'd1);
    chk("wrgo_g0", g(0), glyph(7'h4B, 11'd5, 11'd7));

    // Reset during START of the second glyph
    rend_lat = 4;
    push_char(7'h41);
    push_char(7'h42);
    glyph_q.delete();
    start_run(11'd0, 11'd0);
    found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      if (bus.char_start && bus.char_code == 7'h42) found = 1'b1;
      else tick();
    end
    chk("rst_mid_reached", 32'(found), 32'd1);
    push_char(7'h55);
    chk("busy_write_ignored", 32'(bus.buf_count), 32'd0);
    reset = 1'b1;
    tick();
    chk("rst_mid_start", 32'(bus.char_start), 32'd0);
    chk("rst_mid_busy",  32'(bus.busy),       32'd0);
    chk("rst_mid_count", 32'(bus.buf_count),  32'd0);
    reset = 1'b0;
    tick();
    start_run(11'd0, 11'd0);
    chk("empty_finished", 32'(bus.finished),   32'd1);
    chk("empty_start",    32'(bus.char_start), 32'd0);
    tick();
    chk("empty_fin_once", 32'(bus.finished),   32'd0);
    chk("empty_idle",     32'(bus.busy),       32'd0);
    chk("empty_no_glyph", 32'(glyph_q.size()), 32'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/text_line_sequencer.md
Name: text_line_sequencer

Overview:
- Sequences the 14-segment character renderer so a whole string is drawn on screen, one glyph after another.
- Buffers up to DEPTH 7-bit character codes loaded by a host while idle. On go, it feeds each code with a computed pen position to the renderer over its start/done handshake.
- Handles newline and right-edge wrap.
- Sits between the host/keyboard logic and the character renderer, which drives the line drawer and frame buffer.

Parameters:
- DEPTH, 16, character buffer entries (power of 2)
- CHAR_PITCH, 25, x advance per glyph in pixels (glyph width 20 + 5 gap)
- LINE_PITCH, 50, y advance per line in pixels (glyph height 40 + 10 gap)
- X_MAX, 639, rightmost usable x pixel
- NEWLINE, 7'h0A, code treated as line break (not drawn)

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  push wr_char into buffer (honoured only in IDLE)
- wr_char  in  7  character code to push
- buf_full  out  1  buffer holds DEPTH codes
- buf_count  out  $clog2(DEPTH)+1  codes currently buffered
- go  in  1  start drawing buffer contents (sampled in IDLE only)
- x_base  in  11  left margin / first glyph x (sampled on go)
- y_base  in  11  first line y (sampled on go)
- busy  out  1  high from the cycle after go until finished
- finished  out  1  one-cycle pulse when the string completes
- char_code  out  7  code to renderer
- char_x0  out  11  renderer x offset
- char_y0  out  11  renderer y offset
- char_start  out  1  renderer start
- char_done  in  1  renderer done

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: state IDLE; buffer cleared (rd/wr pointers 0, buf_count 0); buf_full 0; busy 0; finished 0; char_start 0; char_code/char_x0/char_y0 0; cursors 0.
- Reset mid-operation: aborts immediately. char_start drops the cycle after reset is asserted, and buffer contents are discarded.
- Buffer behaviour:
  - FIFO order.
  - wr_en in IDLE with buf_full=0 writes and increments buf_count the next cycle.
  - wr_en while full, or in any non-IDLE state, is ignored with no state change.
  - wr_en and go in the same IDLE cycle: the write is accepted first, then the run includes that char.
- States:
  - IDLE: on go, latch cur_x=x_base and cur_y=y_base. Go to FETCH if buf_count>0, else DONE.
  - FETCH: pop head into char_code.
    - If code==NEWLINE: cur_x=x_base, cur_y+=LINE_PITCH, then go to NEXT.
    - Else if cur_x+CHAR_PITCH-1 > X_MAX and cur_x != x_base (wrap): cur_x=x_base, cur_y+=LINE_PITCH, then stay in FETCH with the same char (not re-popped).
    - Else drive char_x0=cur_x, char_y0=cur_y, then go to START.
  - START: char_start=1. Hold until char_done=1, then go to RELEASE.
  - RELEASE: char_start=0. Hold until char_done=0 (the renderer only returns to its idle state after start falls), then cur_x+=CHAR_PITCH, go to NEXT.
  - NEXT: if buffer empty go to DONE, else FETCH.
  - DONE: finished=1 for exactly one cycle, then IDLE.
- busy is high in every state except IDLE.
- char_code/x0/y0 are held stable from FETCH through RELEASE.
- Arithmetic:
  - All coordinates are 11-bit unsigned; cur_y wraps modulo 2048 with no clamp.
  - Wrap compare is done at 12 bits to avoid overflow.
  - A glyph never starts with char_x0+CHAR_PITCH-1 > X_MAX unless it is first on its line.
- Latency: go to first char_start = 3 cycles (IDLE→FETCH→START, char_start high in START).
- Per-glyph overhead beyond renderer time is 3 cycles.
- go while busy is ignored.

Test Plan:
- Reset, push 'A','B' (7'h41,7'h42), go with x_base=10, y_base=20:
  - renderer sees (41,x0=10,y0=20) then (42,x0=35,y0=20).
  - finished pulses once; buf_count=0, busy=0 after.
- Push DEPTH+2 codes:
  - buf_full=1 at 16 and buf_count stays 16.
  - the extra two are dropped; the run draws exactly 16 glyphs.
- Push 'H',NEWLINE,'I', x_base=0, y_base=0:
  - glyphs at (0,0) then (0,50).
  - newline generates no char_start.
- x_base=600, push 3 codes:
  - first at (600,0) since 624≤639.
  - second wraps to (600,50) as first on line.
  - third wraps to (600,100).
- Model renderer holding done high until start drops: char_start must stay low until char_done falls, and no glyph is double-drawn.
- Assert reset during START of the second glyph:
  - next cycle char_start=0, busy=0, buf_count=0.
  - subsequent go with an empty buffer gives finished 2 cycles after go, with no char_start.
